apb_scan_controller: RTL and testbench
======================================

Name: apb_scan_controller

Overview:
- Upstream front-end of the cat recognizer. Sits between the APB bus and the pixel memory, weight memory and neuron calculator.
- Implements an APB3 slave with CTRL/STATUS registers and pixel write/read-back.
- On a start command, sequences the pixel/weight address scan that feeds the calculator, then captures its result.
- Owns the shared memory address port: APB owns it when idle, the scan owns it when busy.

Parameters:
- Amba_Word, 24, APB data width and pixel word width
- Amba_Addr_Depth, 12, APB/memory address width
- Num_Pixels, 1024, words scanned per inference (2 ≤ Num_Pixels ≤ 2^Amba_Addr_Depth−2)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- PSEL, PENABLE, PWRITE  in  1 each  APB3 control
- PADDR  in  Amba_Addr_Depth  APB word address
- PWDATA  in  Amba_Word  APB write data
- PRDATA  out  Amba_Word  APB read data (registered)
- PREADY  out  1  APB ready
- PSLVERR  out  1  APB error, valid when PREADY=1 in access phase
- mem_we  out  1  pixel memory write strobe
- mem_re  out  1  pixel+weight memory read strobe
- mem_addr  out  Amba_Addr_Depth  memory address
- mem_wdata  out  Amba_Word  pixel write data
- mem_rdata  in  Amba_Word  pixel memory data, valid 1 cycle after mem_re
- calc_clear  out  1  1-cycle accumulator clear pulse
- calc_valid  out  1  pixel/weight on memory outputs valid this cycle
- calc_last  out  1  high with final calc_valid (get_result)
- calc_done  in  1  calculator result ready (pulse)
- calc_result  in  1  calculator output (cat=1)

Behaviour:
- Map: 0=CTRL (W: bit0 start, bit1 abort; self-clearing, reads 0). 1=STATUS (RO: bit0 busy, bit1 done, bit2 result, rest 0). 2..Num_Pixels+1=pixel words; mem_addr=PADDR−2. Any other address is out of range.
- Reset: all outputs 0; PREADY=0; busy=done=result=0; both FSMs idle.
- APB FSM: A_IDLE → (PSEL & !PENABLE) A_SETUP → A_ACC, or A_RDW for a pixel read. Back to A_IDLE after the access cycle with PREADY=1.
- Writes: zero wait states, PREADY=1 in the first access cycle. For a pixel address, mem_we=1 for exactly that cycle, with mem_addr and mem_wdata driven from PADDR/PWDATA.
- CTRL/STATUS reads: PRDATA loaded during setup; PREADY=1 in the first access cycle.
- Pixel reads: mem_re pulses in setup; first access cycle PREADY=0, PRDATA<=mem_rdata; second access cycle PREADY=1. Exactly one wait state.
- PSLVERR=1 with PREADY in these cases:
  - out-of-range address
  - pixel read or write while busy
  - start while busy
  - write to STATUS
- An errored transfer has no side effect, and its read returns PRDATA=0.
- PRDATA returns to 0 in the cycle after PREADY.
- Scan FSM S_IDLE → S_CLR → S_SCAN → S_FLUSH → S_WAIT:
  - CTRL write with bit0=1 in S_IDLE: busy=1, done=0 from the next cycle; S_CLR asserts calc_clear for 1 cycle.
  - S_SCAN: mem_re=1 every cycle, mem_addr 0..Num_Pixels−1 (Num_Pixels cycles).
  - calc_valid follows mem_re by 1 cycle; calc_last coincides with calc_valid for address Num_Pixels−1 (S_FLUSH).
  - S_WAIT: hold until calc_done=1, then result<=calc_result, done=1, busy=0, go to S_IDLE.
  - calc_done in the same cycle as calc_last is accepted.
- Abort (CTRL bit1=1) while busy: at the next edge go to S_IDLE, busy=0, done=0, plus one calc_clear pulse; no result captured.
- Abort while idle: no effect. Start and abort in the same write: abort wins.
- STATUS reads are legal at all times, including during a scan.
- The scan owns mem_addr/mem_re while busy. APB never drives the memory while busy, so the two never conflict.
- calc_done outside S_WAIT is ignored.
- Async reset mid-scan or mid-transfer: immediate return to reset values; the memory contents are untouched.

Test Plan:
- Reset, then write PWDATA=0x00ABCD to PADDR=2 → one cycle with mem_we=1, mem_addr=0, mem_wdata=0x00ABCD; PREADY=1, PSLVERR=0. Read PADDR=2 with mem_rdata=0x00ABCD → PREADY low 1 cycle, then PRDATA=0x00ABCD.
- Num_Pixels=4: write CTRL=0x1 → calc_clear pulse; mem_re for 4 cycles with mem_addr 0,1,2,3; calc_valid lagging by 1; calc_last with the 4th. Drive calc_done=1, calc_result=1 → STATUS reads 0x6.
- During a scan: pixel write to PADDR=3 → PSLVERR=1, no mem_we. STATUS read → 0x1. CTRL=0x1 → PSLVERR=1, scan unaffected.
- Read PADDR=Num_Pixels+2 (out of range) → PSLVERR=1, PRDATA=0. Write to PADDR=1 → PSLVERR=1, STATUS unchanged.
- CTRL=0x2 mid-scan (after mem_addr=1) → next cycle busy=0, calc_clear pulse, mem_re=0; a later calc_done is ignored, STATUS=0x0.
- Pull rst low while mem_addr=2 in S_SCAN → mem_re, calc_valid, busy and PREADY drop to 0 immediately. After release, CTRL=0x1 → a full scan from address 0.

Source files
------------

// File: rtl/apb_scan_controller_if.sv
// APB3 bus bundle between the host and the scan controller front-end.
// The master modport belongs to the bus driver; the slave modport belongs to the controller.
interface apb_scan_controller_if #(
  parameter int Amba_Word       = 24,
  parameter int Amba_Addr_Depth = 12
) ();
  logic                       PSEL;
  logic                       PENABLE;
  logic                       PWRITE;
  logic [Amba_Addr_Depth-1:0] PADDR;
  logic [Amba_Word-1:0]       PWDATA;
  logic [Amba_Word-1:0]       PRDATA;
  logic                       PREADY;
  logic                       PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_scan_controller.sv
// APB3 front-end of the cat recognizer: CTRL/STATUS registers, pixel access, and the
// pixel/weight address scan that feeds the neuron calculator.
module apb_scan_controller #(
  parameter int Amba_Word       = 24,
  parameter int Amba_Addr_Depth = 12,
  parameter int Num_Pixels      = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  apb_scan_controller_if.slave       apb,
  output logic                       mem_we,
  output logic                       mem_re,
  output logic [Amba_Addr_Depth-1:0] mem_addr,
  output logic [Amba_Word-1:0]       mem_wdata,
  input  logic [Amba_Word-1:0]       mem_rdata,
  output logic                       calc_clear,
  output logic                       calc_valid,
  output logic                       calc_last,
  input  logic                       calc_done,
  input  logic                       calc_result,
  output logic [1:0]                 dbg_apb_state,
  output logic [2:0]                 dbg_scan_state
);
  localparam logic [Amba_Addr_Depth-1:0] PixBase = Amba_Addr_Depth'(2);
  localparam logic [Amba_Addr_Depth-1:0] PixLast = Amba_Addr_Depth'(Num_Pixels + 1);
  localparam logic [Amba_Addr_Depth-1:0] CntLast = Amba_Addr_Depth'(Num_Pixels - 1);

  // The bus setup phase is decoded while in A_IDLE, so A_ACC is the first access cycle.
  typedef enum logic [1:0] {A_IDLE, A_ACC, A_RDW} apb_state_e;
  typedef enum logic [2:0] {S_IDLE, S_CLR, S_SCAN, S_FLUSH, S_WAIT} scan_state_e;

  apb_state_e                 apb_q, apb_d;
  scan_state_e                scan_q, scan_d;
  logic                       err_q, err_d;
  logic [Amba_Word-1:0]       prdata_q, prdata_d;
  logic [Amba_Addr_Depth-1:0] cnt_q, cnt_d;
  logic                       done_q, done_d;
  logic                       result_q, result_d;
  logic                       abort_clr_q, abort_clr_d;

  logic                 setup_phase, is_ctrl, is_stat, is_pix, busy;
  logic                 start_req, abort_req, bad_xfer;
  logic                 apb_rd_strobe, apb_wr_strobe, ctrl_wr, start_cmd, abort_cmd;
  logic [Amba_Word-1:0] status_word;

  assign setup_phase = apb.PSEL && !apb.PENABLE;
  assign is_ctrl     = (apb.PADDR == '0);
  assign is_stat     = (apb.PADDR == Amba_Addr_Depth'(1));
  assign is_pix      = (apb.PADDR >= PixBase) && (apb.PADDR <= PixLast);
  assign busy        = (scan_q != S_IDLE);
  assign start_req   = apb.PWDATA[0] && !apb.PWDATA[1];
  assign abort_req   = apb.PWDATA[1];
  assign status_word = {{(Amba_Word-3){1'b0}}, result_q, done_q, busy};

  // A start that carries the abort bit is an abort, so it is never a start-while-busy error.
  assign bad_xfer = !(is_ctrl || is_stat || is_pix)
                 || (is_pix && busy)
                 || (apb.PWRITE && is_ctrl && start_req && busy)
                 || (apb.PWRITE && is_stat);

  // APB holds PADDR/PWDATA stable across setup and access, so access-cycle decode is live.
  assign apb_rd_strobe = (apb_q == A_IDLE) && setup_phase && !apb.PWRITE && is_pix && !bad_xfer;
  assign apb_wr_strobe = (apb_q == A_ACC) && !err_q && apb.PWRITE && is_pix;
  assign ctrl_wr       = (apb_q == A_ACC) && !err_q && apb.PWRITE && is_ctrl;
  assign start_cmd     = ctrl_wr && start_req && !busy;
  assign abort_cmd     = ctrl_wr && abort_req && busy;

  always_comb begin
    apb_d    = apb_q;
    err_d    = err_q;
    prdata_d = '0;
    case (apb_q)
      A_IDLE: begin
        if (setup_phase) begin
          err_d = bad_xfer;
          if (!apb.PWRITE && !bad_xfer && is_pix) begin
            apb_d = A_RDW;
          end else begin
            apb_d = A_ACC;
            if (!apb.PWRITE && !bad_xfer && is_stat) prdata_d = status_word;
          end
        end
      end
      A_RDW: begin
        prdata_d = mem_rdata;
        apb_d    = A_ACC;
      end
      A_ACC:   apb_d = A_IDLE;
      default: apb_d = A_IDLE;
    endcase
  end

  always_comb begin
    scan_d      = scan_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    result_d    = result_q;
    abort_clr_d = 1'b0;
    if (abort_cmd) begin
      scan_d      = S_IDLE;
      cnt_d       = '0;
      done_d      = 1'b0;
      abort_clr_d = 1'b1;
    end else begin
      case (scan_q)
        S_IDLE: begin
          if (start_cmd) begin
            scan_d   = S_CLR;
            done_d   = 1'b0;
            result_d = 1'b0;
          end
        end
        S_CLR: begin
          cnt_d  = '0;
          scan_d = S_SCAN;
        end
        S_SCAN: begin
          if (cnt_q == CntLast) scan_d = S_FLUSH;
          else                  cnt_d  = cnt_q + Amba_Addr_Depth'(1);
        end
        // The calculator may answer in the same cycle as calc_last.
        S_FLUSH, S_WAIT: begin
          if (calc_done) begin
            result_d = calc_result;
            done_d   = 1'b1;
            scan_d   = S_IDLE;
          end else begin
            scan_d = S_WAIT;
          end
        end
        default: scan_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      apb_q       <= A_IDLE;
      scan_q      <= S_IDLE;
      err_q       <= 1'b0;
      prdata_q    <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      result_q    <= 1'b0;
      abort_clr_q <= 1'b0;
    end else begin
      apb_q       <= apb_d;
      scan_q      <= scan_d;
      err_q       <= err_d;
      prdata_q    <= prdata_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      result_q    <= result_d;
      abort_clr_q <= abort_clr_d;
    end
  end

  always_comb begin
    mem_addr = '0;
    if (scan_q == S_SCAN)                    mem_addr = cnt_q;
    else if (apb_rd_strobe || apb_wr_strobe) mem_addr = apb.PADDR - PixBase;
  end

  assign mem_we     = apb_wr_strobe;
  assign mem_re     = (scan_q == S_SCAN) || apb_rd_strobe;
  assign mem_wdata  = apb_wr_strobe ? apb.PWDATA : '0;
  assign calc_clear = (scan_q == S_CLR) || abort_clr_q;
  assign calc_valid = ((scan_q == S_SCAN) && (cnt_q != '0)) || (scan_q == S_FLUSH);
  assign calc_last  = (scan_q == S_FLUSH);

  assign apb.PREADY  = (apb_q == A_ACC);
  assign apb.PSLVERR = (apb_q == A_ACC) && err_q;
  assign apb.PRDATA  = prdata_q;

  assign dbg_apb_state  = apb_q;
  assign dbg_scan_state = scan_q;
endmodule

// File: tb/tb_apb_scan_controller.sv
// Directed bench for apb_scan_controller with a 4-pixel scan; expected APB completions and
// memory/calculator strobe cycles are queued by the drivers and checked by a negedge monitor.
module tb_apb_scan_controller;
  localparam int W  = 24;
  localparam int AD = 12;
  localparam int NP = 4;

  logic          clk;
  logic          rst;
  logic          mem_we, mem_re;
  logic [AD-1:0] mem_addr;
  logic [W-1:0]  mem_wdata, mem_rdata;
  logic          calc_clear, calc_valid, calc_last, calc_done, calc_result;
  logic [1:0]    dbg_apb_state;
  logic [2:0]    dbg_scan_state;

  apb_scan_controller_if #(.Amba_Word(W), .Amba_Addr_Depth(AD)) bus ();

  apb_scan_controller #(.Amba_Word(W), .Amba_Addr_Depth(AD), .Num_Pixels(NP)) dut (
    .clk            (clk),
    .rst            (rst),
    .apb            (bus),
    .mem_we         (mem_we),
    .mem_re         (mem_re),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .calc_clear     (calc_clear),
    .calc_valid     (calc_valid),
    .calc_last      (calc_last),
    .calc_done      (calc_done),
    .calc_result    (calc_result),
    .dbg_apb_state  (dbg_apb_state),
    .dbg_scan_state (dbg_scan_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- pixel memory model ----------------
  logic [W-1:0] pix_mem [0:NP-1];
  always @(posedge clk) begin
    if (mem_we) pix_mem[mem_addr[1:0]] <= mem_wdata;
    if (mem_re) mem_rdata <= pix_mem[mem_addr[1:0]];
  end

  // ---------------- scoreboard ----------------
  // apb entry: {waits[1:0], pslverr, prdata[23:0]}
  // event entry: {we, re, addr[11:0], wdata[23:0], clear, valid, last}
  logic [26:0] apb_exp_q[$];
  logic [40:0] ev_exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got event want none", name);
  endtask

  function automatic logic [40:0] ev(input logic we, input logic re, input logic [AD-1:0] a,
                                     input logic [W-1:0] d, input logic c, input logic v,
                                     input logic l);
    return {we, re, a, d, c, v, l};
  endfunction

  int   waits;
  logic prev_ready;
  logic [26:0] ae;
  logic [40:0] ee;
  always @(negedge clk) begin
    if (!rst) begin
      waits      = 0;
      prev_ready = 1'b0;
    end else begin
      if (prev_ready) check("prdata_after_ready", 64'(bus.PRDATA), 64'd0);
      if (bus.PSEL && bus.PENABLE && !bus.PREADY) waits++;
      if (bus.PREADY) begin
        if (apb_exp_q.size() == 0) fail_now("apb_unexpected");
        else begin
          ae = apb_exp_q.pop_front();
          check("apb_prdata", 64'(bus.PRDATA), 64'(ae[23:0]));
          check("apb_pslverr", 64'(bus.PSLVERR), 64'(ae[24]));
          check("apb_waits", 64'(waits), 64'(ae[26:25]));
        end
        waits = 0;
      end
      prev_ready = bus.PREADY;
      if (mem_we || mem_re || calc_clear || calc_valid || calc_last) begin
        if (ev_exp_q.size() == 0) fail_now("event_unexpected");
        else begin
          ee = ev_exp_q.pop_front();
          check("event", 64'(ev(mem_we, mem_re, mem_addr, mem_wdata, calc_clear, calc_valid,
                                calc_last)), 64'(ee));
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic apb_xfer(input logic wr, input logic [AD-1:0] addr, input logic [W-1:0] wdata,
                          input logic err, input logic [W-1:0] rdata, input logic [1:0] nwait);
    int k;
    apb_exp_q.push_back({nwait, err, rdata});
    @(posedge clk); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = addr; bus.PWDATA = wdata;
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    k = 0;
    while (!bus.PREADY && k < 8) begin
      @(posedge clk); #1;
      k++;
    end
    if (k == 8) check("apb_timeout", 64'(k), 64'd0);
    @(posedge clk); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic pix_write(input logic [AD-1:0] addr, input logic [W-1:0] d);
    ev_exp_q.push_back(ev(1'b1, 1'b0, addr - 12'd2, d, 1'b0, 1'b0, 1'b0));
    apb_xfer(1'b1, addr, d, 1'b0, '0, 2'd0);
  endtask

  task automatic pix_read(input logic [AD-1:0] addr, input logic [W-1:0] d);
    ev_exp_q.push_back(ev(1'b0, 1'b1, addr - 12'd2, '0, 1'b0, 1'b0, 1'b0));
    apb_xfer(1'b0, addr, '0, 1'b0, d, 2'd1);
  endtask

  task automatic status_read(input logic [W-1:0] st);
    apb_xfer(1'b0, 12'd1, '0, 1'b0, st, 2'd0);
  endtask

  task automatic push_full_scan();
    ev_exp_q.push_back(ev(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < NP; i++)
      ev_exp_q.push_back(ev(1'b0, 1'b1, 12'(i), '0, 1'b0, 1'(i != 0), 1'b0));
    ev_exp_q.push_back(ev(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1));
  endtask

  task automatic pulse_done(input logic res);
    @(posedge clk); #1;
    calc_done = 1'b1; calc_result = res;
    @(posedge clk); #1;
    calc_done = 1'b0; calc_result = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    rst = 1'b0;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0; bus.PWDATA = '0;
    calc_done = 1'b0; calc_result = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pready", 64'(bus.PREADY), 64'd0);
    check("rst_pslverr", 64'(bus.PSLVERR), 64'd0);
    check("rst_prdata", 64'(bus.PRDATA), 64'd0);
    check("rst_mem", 64'({mem_we, mem_re, mem_addr, mem_wdata}), 64'd0);
    check("rst_calc", 64'({calc_clear, calc_valid, calc_last}), 64'd0);
    check("rst_states", 64'({dbg_apb_state, dbg_scan_state}), 64'd0);
    rst = 1'b1;
    status_read(24'h0);

    // pixel write/read-back, first and last pixel words
    pix_write(12'd2, 24'h00ABCD);
    pix_read(12'd2, 24'h00ABCD);
    pix_write(12'd5, 24'h123456);
    pix_read(12'd5, 24'h123456);
    apb_xfer(1'b0, 12'd6, '0, 1'b1, '0, 2'd0);          // one past the last pixel
    apb_xfer(1'b1, 12'hFFF, 24'h777777, 1'b1, '0, 2'd0);

    // full scan with errored traffic while busy
    push_full_scan();
    apb_xfer(1'b1, 12'd0, 24'h1, 1'b0, '0, 2'd0);
    status_read(24'h1);
    apb_xfer(1'b1, 12'd3, 24'h555555, 1'b1, '0, 2'd0);
    apb_xfer(1'b0, 12'd2, '0, 1'b1, '0, 2'd0);
    apb_xfer(1'b1, 12'd0, 24'h1, 1'b1, '0, 2'd0);
    status_read(24'h1);
    pulse_done(1'b1);
    status_read(24'h6);

    apb_xfer(1'b1, 12'd1, 24'h0, 1'b1, '0, 2'd0);       // STATUS is read-only
    status_read(24'h6);
    apb_xfer(1'b1, 12'd0, 24'h2, 1'b0, '0, 2'd0);       // abort while idle
    status_read(24'h6);
    apb_xfer(1'b0, 12'd0, '0, 1'b0, '0, 2'd0);          // CTRL reads zero

    // abort after the scan has presented address 1
    ev_exp_q.push_back(ev(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0));
    ev_exp_q.push_back(ev(1'b0, 1'b1, 12'd0, '0, 1'b0, 1'b0, 1'b0));
    ev_exp_q.push_back(ev(1'b0, 1'b1, 12'd1, '0, 1'b0, 1'b1, 1'b0));
    ev_exp_q.push_back(ev(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0));
    apb_xfer(1'b1, 12'd0, 24'h1, 1'b0, '0, 2'd0);
    apb_xfer(1'b1, 12'd0, 24'h2, 1'b0, '0, 2'd0);
    pulse_done(1'b1);
    status_read(24'h0);
    apb_xfer(1'b1, 12'd0, 24'h3, 1'b0, '0, 2'd0);       // start+abort while idle: nothing
    status_read(24'h0);

    // asynchronous reset while the scan presents address 2
    ev_exp_q.push_back(ev(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0));
    ev_exp_q.push_back(ev(1'b0, 1'b1, 12'd0, '0, 1'b0, 1'b0, 1'b0));
    ev_exp_q.push_back(ev(1'b0, 1'b1, 12'd1, '0, 1'b0, 1'b1, 1'b0));
    apb_xfer(1'b1, 12'd0, 24'h1, 1'b0, '0, 2'd0);
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_addr", 64'(mem_addr), 64'd2);
    check("pre_rst_re", 64'(mem_re), 64'd1);
    rst = 1'b0;
    #1;
    check("async_rst_outs", 64'({mem_re, calc_valid, bus.PREADY}), 64'd0);
    check("async_rst_scan", 64'(dbg_scan_state), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    status_read(24'h0);

    // full scan, calculator answers in the calc_last cycle
    push_full_scan();
    apb_xfer(1'b1, 12'd0, 24'h1, 1'b0, '0, 2'd0);
    k = 0;
    while (!calc_last && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    check("wait_calc_last", 64'(calc_last), 64'd1);
    calc_done = 1'b1; calc_result = 1'b0;
    @(posedge clk); #1;
    calc_done = 1'b0;
    status_read(24'h2);
    pix_read(12'd2, 24'h00ABCD);                        // memory survives reset
    pix_read(12'd5, 24'h123456);

    repeat (5) @(posedge clk);
    check("apb_left", 64'(apb_exp_q.size()), 64'd0);
    check("event_left", 64'(ev_exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
